// File: rtl/paddle_axis_pkg.sv
// Shared field positions of the hps_io mouse word and the saturating adder
// used by both paddle axis accumulators.
package paddle_axis_pkg;

    localparam int STB_BIT = 24;
    localparam int DX_SIGN = 4;
    localparam int DY_SIGN = 5;
    localparam int DX_LSB  = 8;
    localparam int DY_LSB  = 16;
    localparam int BTN_MSB = 2;

    // Add in a wide signed domain, then pin the result to the signed range of width bits.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] acc,
                                                   input logic signed [31:0] delta,
                                                   input int width);
        logic signed [31:0] sum;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        sum = acc + delta;
        hi  = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo  = -(32'sd1 <<< (width - 1));
        if (sum > hi) begin
            sat_add = hi;
        end else if (sum < lo) begin
            sat_add = lo;
        end else begin
            sat_add = sum;
        end
    endfunction

endpackage

// File: rtl/paddle_axis_mapper_accum.sv
// One paddle axis: scales and clamps a raw 9-bit mouse delta, then keeps a
// saturating signed accumulator with clear, event and spring-decay strobes.
module axis_accum
    import paddle_axis_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_STEP = 10
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [8:0]              delta_i,
    input  logic [1:0]              sens_i,
    input  logic                    clr_i,
    input  logic                    evt_i,
    input  logic                    decay_i,
    output logic signed [WIDTH-1:0] acc_o
);

    logic signed [WIDTH-1:0] acc_q, acc_d;
    logic signed [8:0]       shifted;
    logic signed [31:0]      step;
    logic signed [31:0]      sum;

    always_comb begin
        shifted = $signed(delta_i) >>> sens_i;
        step    = $signed({{23{shifted[8]}}, shifted});
        if (step > MAX_STEP) begin
            step = MAX_STEP;
        end else if (step < -MAX_STEP) begin
            step = -MAX_STEP;
        end
        sum   = sat_add($signed({{(32-WIDTH){acc_q[WIDTH-1]}}, acc_q}), step, WIDTH);
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (evt_i) begin
            acc_d = sum[WIDTH-1:0];
        end else if (decay_i) begin
            // Step one toward zero; zero itself is left alone.
            if (acc_q[WIDTH-1]) begin
                acc_d = acc_q + WIDTH'(1);
            end else if (acc_q != '0) begin
                acc_d = acc_q + {WIDTH{1'b1}};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/paddle_axis_mapper.sv
// Mouse / analog-stick to paddle mapper: strobe detection, source arbitration,
// spring-decay timing and output muxing around two axis accumulators.
module paddle_axis_mapper
    import paddle_axis_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MAX_STEP   = 10,
    parameter int CENTER_DIV = 65536
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic [24:0]      ps2_mouse,
    input  logic [15:0]      joya,
    input  logic [2:0]       joy_btn,
    input  logic [1:0]       sens,
    input  logic [1:0]       invert,
    input  logic             spring,
    input  logic             recenter,
    output logic [WIDTH-1:0] axis_x,
    output logic [WIDTH-1:0] axis_y,
    output logic [2:0]       btn,
    output logic             mouse_active
);

    localparam int CNT_W = $clog2(CENTER_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CENTER_DIV - 1);

    logic             armed_q, old_stb_q;
    logic             active_q, active_d;
    logic [2:0]       btn_q, btn_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             strobe_evt, joy_nz, clr, evt, decay;
    logic signed [WIDTH-1:0] acc_x, acc_y;
    logic signed [7:0]       joy_x8, joy_y8;
    logic [WIDTH-1:0]        raw_x, raw_y;

    always_comb begin
        strobe_evt = armed_q && (ps2_mouse[STB_BIT] != old_stb_q);
        joy_nz     = |joya;
        clr        = joy_nz | recenter;
        // A stick deflection or recentre swallows a same-cycle mouse packet.
        evt        = strobe_evt & ~clr;
        active_d   = active_q;
        btn_d      = btn_q;
        cnt_d      = '0;
        decay      = 1'b0;
        if (joy_nz) begin
            active_d = 1'b0;
        end else if (evt) begin
            active_d = 1'b1;
            btn_d    = ps2_mouse[BTN_MSB:0];
        end
        if (spring && !clr && !strobe_evt) begin
            if (cnt_q == CNT_LAST) begin
                decay = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            armed_q   <= 1'b0;
            old_stb_q <= 1'b0;
            active_q  <= 1'b0;
            btn_q     <= '0;
            cnt_q     <= '0;
        end else begin
            armed_q   <= 1'b1;
            old_stb_q <= ps2_mouse[STB_BIT];
            active_q  <= active_d;
            btn_q     <= btn_d;
            cnt_q     <= cnt_d;
        end
    end

    axis_accum #(.WIDTH(WIDTH), .MAX_STEP(MAX_STEP)) u_acc_x (
        .clk_i   (clk_sys),
        .rst_ni  (reset_n),
        .delta_i ({ps2_mouse[DX_SIGN], ps2_mouse[DX_LSB +: 8]}),
        .sens_i  (sens),
        .clr_i   (clr),
        .evt_i   (evt),
        .decay_i (decay),
        .acc_o   (acc_x)
    );

    axis_accum #(.WIDTH(WIDTH), .MAX_STEP(MAX_STEP)) u_acc_y (
        .clk_i   (clk_sys),
        .rst_ni  (reset_n),
        .delta_i ({ps2_mouse[DY_SIGN], ps2_mouse[DY_LSB +: 8]}),
        .sens_i  (sens),
        .clr_i   (clr),
        .evt_i   (evt),
        .decay_i (decay),
        .acc_o   (acc_y)
    );

    always_comb begin
        joy_x8 = joya[7:0];
        joy_y8 = joya[15:8];
        raw_x  = active_q ? acc_x : WIDTH'(joy_x8);
        raw_y  = active_q ? acc_y : WIDTH'(joy_y8);
    end

    assign axis_x       = invert[0] ? ~raw_x : raw_x;
    assign axis_y       = invert[1] ? ~raw_y : raw_y;
    assign btn          = active_q ? btn_q : joy_btn;
    assign mouse_active = active_q;

endmodule

// File: tb/tb_paddle_axis_mapper.sv
// Scoreboard bench for paddle_axis_mapper: an integer reference model predicts
// the outputs of every cycle; a negedge monitor pops and compares them.
module tb_paddle_axis_mapper;

    localparam int WIDTH = 8;
    localparam int MSTEP = 10;
    localparam int CDIV  = 4;
    localparam int AMAX  = 127;
    localparam int AMIN  = -128;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [24:0] ps2_mouse;
    logic [15:0] joya;
    logic [2:0]  joy_btn;
    logic [1:0]  sens;
    logic [1:0]  invert;
    logic        spring;
    logic        recenter;
    logic [7:0]  axis_x, axis_y;
    logic [2:0]  btn;
    logic        mouse_active;

    paddle_axis_mapper #(.WIDTH(WIDTH), .MAX_STEP(MSTEP), .CENTER_DIV(CDIV)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ps2_mouse    (ps2_mouse),
        .joya         (joya),
        .joy_btn      (joy_btn),
        .sens         (sens),
        .invert       (invert),
        .spring       (spring),
        .recenter     (recenter),
        .axis_x       (axis_x),
        .axis_y       (axis_y),
        .btn          (btn),
        .mouse_active (mouse_active)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] b;
        logic       ma;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state
    int       m_acc [2];
    bit       m_ma, m_armed, m_old;
    bit [2:0] m_btn;
    int       m_cnt;
    bit       stb;

    function automatic int byte_val(input bit s, input bit [7:0] v);
        return s ? int'(v) - 256 : int'(v);
    endfunction

    function automatic int scale(input int d, input int sh);
        int p, q;
        p = 1 << sh;
        q = (d >= 0) ? d / p : -((-d + p - 1) / p);
        if (q > MSTEP) q = MSTEP;
        if (q < -MSTEP) q = -MSTEP;
        return q;
    endfunction

    function automatic logic [7:0] out_val(input int acc, input bit ma, input bit [7:0] jb, input bit inv);
        int   raw;
        logic [7:0] r;
        raw = ma ? acc : byte_val(jb[7], jb);
        r   = raw[7:0];
        return inv ? 8'(255 - int'(r)) : r;
    endfunction

    task automatic m_reset();
        m_acc[0] = 0; m_acc[1] = 0;
        m_ma = 0; m_armed = 0; m_old = 0; m_btn = '0; m_cnt = 0;
    endtask

    task automatic m_step();
        bit ev;
        int d [2];
        int s;
        if (!reset_n) begin
            m_reset();
            return;
        end
        ev      = m_armed && (ps2_mouse[24] != m_old);
        m_old   = ps2_mouse[24];
        m_armed = 1;
        if (joya != 0) begin
            m_acc[0] = 0; m_acc[1] = 0; m_ma = 0; m_cnt = 0;
        end else if (recenter) begin
            m_acc[0] = 0; m_acc[1] = 0; m_cnt = 0;
        end else if (ev) begin
            d[0] = byte_val(ps2_mouse[4], ps2_mouse[15:8]);
            d[1] = byte_val(ps2_mouse[5], ps2_mouse[23:16]);
            for (int i = 0; i < 2; i++) begin
                s = m_acc[i] + scale(d[i], int'(sens));
                m_acc[i] = (s > AMAX) ? AMAX : (s < AMIN) ? AMIN : s;
            end
            m_ma = 1; m_btn = ps2_mouse[2:0]; m_cnt = 0;
        end else if (spring) begin
            if (m_cnt == CDIV - 1) begin
                m_cnt = 0;
                for (int i = 0; i < 2; i++) begin
                    if (m_acc[i] > 0) m_acc[i]--;
                    else if (m_acc[i] < 0) m_acc[i]++;
                end
            end else begin
                m_cnt++;
            end
        end else begin
            m_cnt = 0;
        end
    endtask

    function automatic exp_t m_expect();
        exp_t e;
        e.x  = out_val(m_acc[0], m_ma, joya[7:0], invert[0]);
        e.y  = out_val(m_acc[1], m_ma, joya[15:8], invert[1]);
        e.b  = m_ma ? m_btn : joy_btn;
        e.ma = m_ma;
        return e;
    endfunction

    // Inputs are stable from posedge+1; push the prediction, clock, advance the model.
    task automatic cycle();
        sb.push_back(m_expect());
        @(posedge clk_sys);
        m_step();
        #1;
    endtask

    task automatic pkt(input int dx, input int dy, input bit [2:0] b);
        logic [8:0] x9, y9;
        x9 = dx[8:0];
        y9 = dy[8:0];
        stb = ~stb;
        ps2_mouse = {stb, y9[7:0], x9[7:0], 2'b00, y9[8], x9[8], 1'b0, b};
        cycle();
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk_sys) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            vectors++;
            if ({axis_x, axis_y, btn, mouse_active} !== e) begin
                miscompares++;
                $display("FAIL scoreboard: got x=%h y=%h btn=%b ma=%b expected x=%h y=%h btn=%b ma=%b at %0t",
                         axis_x, axis_y, btn, mouse_active, e.x, e.y, e.b, e.ma, $time);
            end
        end
    end

    initial begin
        stb = 1'b1;
        reset_n = 1'b0; ps2_mouse = 25'h1000000; joya = '0; joy_btn = 3'b010;
        sens = '0; invert = '0; spring = 1'b0; recenter = 1'b0;
        m_reset();
        @(posedge clk_sys); #1;
        cycle(); cycle();
        chk("reset_axis_x", axis_x, 8'h00);
        chk("reset_btn", btn, 3'b010);
        reset_n = 1'b1;
        cycle(); cycle();
        chk("arm_no_event", mouse_active, 1'b0);

        // Positive delta clamps to MAX_STEP and accumulates to saturation.
        pkt(50, 0, 3'b101);
        chk("first_step", axis_x, 8'd10);
        chk("first_active", mouse_active, 1'b1);
        for (int i = 0; i < 12; i++) pkt(50, 0, 3'b101);
        chk("sat_pos", axis_x, 8'd127);
        pkt(50, 0, 3'b101);
        chk("sat_hold", axis_x, 8'd127);

        sens = 2'd1; invert = 2'b10;
        pkt(0, -7, 3'b001);
        chk("inv_y", axis_y, 8'h03);
        pkt(0, -7, 3'b001);
        invert = 2'b00;
        for (int i = 0; i < 40; i++) pkt(-200, -200, 3'b110);
        chk("sat_neg", axis_x, 8'h80);

        // Spring decay, including a packet that restarts the interval.
        recenter = 1'b1; cycle(); recenter = 1'b0;
        sens = 2'd0;
        pkt(3, 0, 3'b000);
        spring = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk("decay_1", axis_x, 8'd2);
        for (int i = 0; i < 10; i++) cycle();
        chk("decay_0", axis_x, 8'd0);
        pkt(3, -2, 3'b000);
        cycle(); cycle();
        pkt(1, 0, 3'b000);
        for (int i = 0; i < 12; i++) cycle();
        spring = 1'b0;

        // Stick, recentre and mouse packet all in one cycle.
        joy_btn = 3'b011; joya = 16'h0020; recenter = 1'b1;
        pkt(5, 5, 3'b111);
        chk("joy_axis_x", axis_x, 8'h20);
        chk("joy_btn", btn, 3'b011);
        chk("joy_inactive", mouse_active, 1'b0);
        joya = '0; recenter = 1'b0;

        // Asynchronous reset mid-operation, then re-arm.
        for (int i = 0; i < 6; i++) pkt(10, 0, 3'b100);
        chk("acc_60", axis_x, 8'd60);
        reset_n = 1'b0;
        m_reset();
        #1;
        chk("async_reset", axis_x, 8'h00);
        cycle(); cycle();
        reset_n = 1'b1;
        stb = ~stb; ps2_mouse[24] = stb;
        cycle();
        chk("rearm_no_event", mouse_active, 1'b0);
        pkt(5, 0, 3'b001);
        chk("rearm_first", axis_x, 8'd5);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            joya     = ($urandom_range(7) == 0) ? 16'($urandom) : 16'h0000;
            recenter = ($urandom_range(15) == 0);
            spring   = ($urandom_range(3) != 0);
            sens     = 2'($urandom);
            invert   = 2'($urandom);
            joy_btn  = 3'($urandom);
            reset_n  = ($urandom_range(199) != 0);
            if (!reset_n) m_reset();
            if ($urandom_range(2) == 0) pkt($urandom_range(511) - 256, $urandom_range(511) - 256, 3'($urandom));
            else cycle();
        end
        reset_n = 1'b1; joya = '0;
        cycle();
        @(negedge clk_sys); #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
